// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird game sequencer: state encoding and
// screen geometry.
package flappy_pkg;

    localparam int         SCREEN_H        = 480;
    localparam logic [8:0] FLOOR_Y_DEFAULT = 9'd464;
    localparam int         STATE_W         = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one registered pulse every FRAME_DIV clocks,
// first pulse in cycle FRAME_DIV after reset release.
module frame_tick_gen #(
    parameter int FRAME_DIV = 1666667
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int            CW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (cnt == LAST);
            cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: IDLE/PLAY/DYING/OVER FSM, per-frame flap request, physics
// and pipe gating, current and high score.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int         FRAME_DIV    = 1666667,
    parameter int         DEATH_FRAMES = 60,
    parameter logic [8:0] FLOOR_Y      = FLOOR_Y_DEFAULT,
    parameter int         SCORE_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flap,
    input  logic               collide,
    input  logic               pipe_passed,
    input  logic [8:0]         bird_y,
    output logic               frame_tick,
    output logic               phys_en,
    output logic               flap_req,
    output logic               bird_rst,
    output logic               pipe_en,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int            DW         = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

    game_state_t   state_q, state_nx;
    logic          flap_q, flap_pend;
    logic [DW-1:0] death_cnt;
    logic          flap_edge, floor_hit;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick)
    );

    assign flap_edge = flap & ~flap_q;
    assign floor_hit = (bird_y >= FLOOR_Y);

    // Outputs decode only registered state and the registered tick.
    assign phys_en  = frame_tick & ((state_q == ST_PLAY) | (state_q == ST_DYING));
    assign flap_req = frame_tick & (state_q == ST_PLAY) & flap_pend;
    assign bird_rst = (state_q == ST_IDLE);
    assign pipe_en  = (state_q == ST_PLAY);
    assign state    = state_q;

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:  if (flap_edge) state_nx = ST_PLAY;
            ST_PLAY:  if (frame_tick && (collide || floor_hit)) state_nx = ST_DYING;
            ST_DYING: if (frame_tick && (floor_hit || death_cnt == DEATH_LAST)) state_nx = ST_OVER;
            ST_OVER:  if (flap_edge) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flap_q    <= 1'b0;
            flap_pend <= 1'b0;
            death_cnt <= '0;
        end else begin
            state_q <= state_nx;
            flap_q  <= flap;
            // A new edge beats the clear, so an edge on the tick itself carries to the next frame.
            if (state_q == ST_PLAY) begin
                if (flap_edge)     flap_pend <= 1'b1;
                else if (flap_req) flap_pend <= 1'b0;
            end else begin
                flap_pend <= 1'b0;
            end
            if (state_q == ST_DYING) begin
                if (frame_tick) death_cnt <= death_cnt + 1'b1;
            end else begin
                death_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
        end else begin
            if (state_q == ST_IDLE && flap_edge)
                score <= '0;
            else if (state_q == ST_PLAY && pipe_passed && score != '1)
                score <= score + 1'b1;
            if (state_q == ST_DYING && state_nx == ST_OVER && score > high_score)
                high_score <= score;
        end
    end

endmodule
